// File: rtl/bitables_pkg.sv
// Shared 512-bit AXI-stream types plus the round-robin arbiter's state and keep
// constants.
package bitables_pkg;

    typedef struct packed {
        logic [511:0] tdata;
        logic [15:0]  tkeep;
        logic         tlast;
        logic         tvalid;
    } axis512_t;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic logic_error;
    } fifo_errors_t;

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } arb_state_e;

    localparam logic [15:0] AXIS512_KEEP_ALL = 16'hFFFF;

    // Error flags raised by one accepted beat; at_limit means the beat count has hit the packet limit.
    function automatic fifo_errors_t beat_errors(input logic [15:0] keep,
                                                 input logic        last,
                                                 input logic        at_limit);
        fifo_errors_t e;
        e.overflow    = !last && at_limit;
        e.underflow   = last && (keep == 16'h0000);
        e.logic_error = !last && (keep != AXIS512_KEEP_ALL);
        return e;
    endfunction

endpackage

// File: rtl/axis512_reg_slice.sv
// Single-entry output register for a 512-bit stream. It holds its beat while
// downstream stalls and accepts a new beat when empty or draining.
module axis512_reg_slice
    import bitables_pkg::*;
(
    input  logic     clk,
    input  logic     arst_n,
    input  logic     load_i,
    input  axis512_t data_i,
    input  logic     m_tready_i,
    output axis512_t m_axis_o,
    output logic     ready_o
);

    axis512_t data_q;
    axis512_t data_d;

    assign ready_o  = !data_q.tvalid || m_tready_i;
    assign m_axis_o = data_q;

    // Load, drain to empty, or hold under back-pressure.
    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = data_i;
        end else if (m_tready_i) begin
            data_d = '0;
        end else begin
            data_d = data_q;
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/axis512_rr_arb.sv
// Packet-granular round-robin merge of NUM_IN 512-bit streams into one stream.
// It also counts the beats of each packet and keeps sticky error flags.
module axis512_rr_arb
    import bitables_pkg::*;
#(
    parameter  int NUM_IN        = 4,
    parameter  int MAX_PKT_BEATS = 256,
    localparam int GW            = $clog2(NUM_IN)
) (
    input  logic              clk,
    input  logic              arst_n,
    input  axis512_t          s_axis_i [NUM_IN],
    output logic [NUM_IN-1:0] s_tready_o,
    output axis512_t          m_axis_o,
    input  logic              m_tready_i,
    output logic [GW-1:0]     grant_o,
    output logic              busy_o,
    input  logic              err_clr_i,
    output fifo_errors_t      errors_o
);

    localparam logic [15:0]   BEAT_LIMIT = 16'(MAX_PKT_BEATS);
    localparam logic [GW-1:0] LAST_IDX   = GW'(NUM_IN - 1);

    arb_state_e    state_q, state_d;
    logic [GW-1:0] ptr_q, ptr_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [15:0]   cnt_q, cnt_d;
    fifo_errors_t  err_q, err_d;

    logic          found_s;
    logic [GW-1:0] pick_s;
    axis512_t      sel_s;
    logic          slice_ready_s;
    logic          fire_s;
    logic [15:0]   cnt_inc_s;

    // First valid input at or after ptr, wrapping.
    always_comb begin
        found_s = 1'b0;
        pick_s  = ptr_q;
        for (int i = 0; i < NUM_IN; i++) begin
            if (!found_s && s_axis_i[(int'(ptr_q) + i) % NUM_IN].tvalid) begin
                found_s = 1'b1;
                pick_s  = GW'((int'(ptr_q) + i) % NUM_IN);
            end else begin
                found_s = found_s;
            end
        end
    end

    assign sel_s     = s_axis_i[grant_q];
    assign fire_s    = (state_q == PASS) && sel_s.tvalid && slice_ready_s;
    assign cnt_inc_s = (cnt_q >= BEAT_LIMIT) ? cnt_q : cnt_q + 16'd1;

    // Only the granted input sees ready, and only when the output register can take a beat.
    always_comb begin
        s_tready_o = '0;
        if ((state_q == PASS) && slice_ready_s) begin
            s_tready_o[grant_q] = 1'b1;
        end else begin
            s_tready_o = '0;
        end
    end

    // Arbitration FSM, beat counter and sticky errors; a new error beats a same-cycle clear.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        err_d   = err_clr_i ? fifo_errors_t'(3'b000) : err_q;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    grant_d = pick_s;
                    state_d = PASS;
                end else begin
                    state_d = IDLE;
                end
            end
            PASS: begin
                if (fire_s) begin
                    err_d = fifo_errors_t'(err_d | beat_errors(sel_s.tkeep, sel_s.tlast,
                                                               cnt_inc_s == BEAT_LIMIT));
                    if (sel_s.tlast) begin
                        cnt_d   = 16'd0;
                        state_d = IDLE;
                        ptr_d   = (grant_q == LAST_IDX) ? GW'(0) : grant_q + GW'(1);
                    end else begin
                        cnt_d   = cnt_inc_s;
                    end
                end else begin
                    state_d = PASS;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            cnt_q   <= 16'd0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    axis512_reg_slice u_out_slice (
        .clk        (clk),
        .arst_n     (arst_n),
        .load_i     (fire_s),
        .data_i     (sel_s),
        .m_tready_i (m_tready_i),
        .m_axis_o   (m_axis_o),
        .ready_o    (slice_ready_s)
    );

    assign grant_o  = grant_q;
    assign busy_o   = (state_q == PASS);
    assign errors_o = err_q;

endmodule

// File: tb/tb_axis512_rr_arb.sv
// Self-checking bench for axis512_rr_arb: arbitration vector table, directed corner
// sequences and randomized traffic against a packet-level round-robin model.
module tb_axis512_rr_arb;
    import bitables_pkg::*;

    localparam int N    = 4;
    localparam int MAXB = 4;

    typedef struct packed {
        logic [511:0] data;
        logic [15:0]  keep;
        logic         last;
    } beat_t;

    typedef struct packed {
        logic [3:0] mask;
        logic [1:0] exp_grant;
    } vec_t;

    logic         clk    = 1'b0;
    logic         arst_n = 1'b0;
    axis512_t     s_axis [N];
    logic [N-1:0] s_tready;
    axis512_t     m_axis;
    logic         m_tready = 1'b1;
    logic [1:0]   grant;
    logic         busy;
    logic         err_clr  = 1'b0;
    fifo_errors_t errors;

    int           total = 0;
    int           bad   = 0;
    beat_t        src_q [N][$];
    beat_t        exp_q [$];
    int           owner_q [$];
    int           model_ptr = 0;
    fifo_errors_t exp_err   = '0;
    vec_t         tv [12];

    always #5 clk = ~clk;

    axis512_rr_arb #(.NUM_IN(N), .MAX_PKT_BEATS(MAXB)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .s_axis_i   (s_axis),
        .s_tready_o (s_tready),
        .m_axis_o   (m_axis),
        .m_tready_i (m_tready),
        .grant_o    (grant),
        .busy_o     (busy),
        .err_clr_i  (err_clr),
        .errors_o   (errors)
    );

    task automatic chk(input string name, input logic [535:0] act, input logic [535:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk_beat(input int k, input logic last, input logic [15:0] keep);
        beat_t b;
        for (int i = 0; i < 16; i++) b.data[i*32 +: 32] = $urandom;
        b.data[31:24] = 8'(k);
        b.keep = keep;
        b.last = last;
        return b;
    endfunction

    task automatic add_pkt(input int k, input int len, input logic [15:0] last_keep);
        for (int b = 0; b < len; b++)
            src_q[k].push_back(mk_beat(k, b == len - 1, (b == len - 1) ? last_keep : 16'hFFFF));
    endtask

    task automatic drive_beat(input int k, input beat_t b, input logic v);
        s_axis[k].tdata  = b.data;
        s_axis[k].tkeep  = b.keep;
        s_axis[k].tlast  = b.last;
        s_axis[k].tvalid = v;
    endtask

    task automatic clear_inputs();
        for (int j = 0; j < N; j++) s_axis[j] = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst_n = 1'b0;
        clear_inputs();
        m_tready = 1'b1;
        err_clr  = 1'b0;
        #1;
        chk("rst_m_axis", m_axis, 530'd0);
        chk("rst_s_tready", s_tready, 4'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", grant, 2'd0);
        chk("rst_errors", errors, 3'd0);
        @(negedge clk);
        arst_n = 1'b1;
        model_ptr = 0;
        exp_err   = '0;
        for (int j = 0; j < N; j++) src_q[j].delete();
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        chk("err_clear", errors, 3'd0);
        exp_err = '0;
    endtask

    // Play the queued packets through the DUT and score them against a packet-level model.
    task automatic run(input int vprob, input int rprob, input int stall_at,
                       input int first_exp, input int gap_exp, input int max_cyc);
        int    rem [N];
        int    idx [N];
        int    bcnt [N];
        logic  mid [N];
        int    p, pick, cyc, outn, last_out, stall_left;
        logic  any;
        beat_t hb;
        exp_q.delete();
        owner_q.delete();
        for (int j = 0; j < N; j++) begin
            rem[j] = 0; idx[j] = 0; bcnt[j] = 0; mid[j] = 1'b0;
            for (int b = 0; b < src_q[j].size(); b++) if (src_q[j][b].last) rem[j]++;
        end
        p = model_ptr;
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            pick = 0;
            for (int i = 0; i < N; i++)
                if (!any && rem[(p + i) % N] > 0) begin any = 1'b1; pick = (p + i) % N; end
            if (any) begin
                owner_q.push_back(pick);
                do begin
                    exp_q.push_back(src_q[pick][idx[pick]]);
                    idx[pick]++;
                end while (!src_q[pick][idx[pick] - 1].last);
                rem[pick]--;
                p = (pick + 1) % N;
            end
        end
        model_ptr = p;

        cyc = 0; outn = 0; last_out = -1; stall_left = 5;
        while (exp_q.size() > 0 && cyc < max_cyc) begin
            @(negedge clk);
            for (int j = 0; j < N; j++) begin
                if (src_q[j].size() > 0)
                    drive_beat(j, src_q[j][0], !mid[j] || ($urandom_range(99) < vprob));
                else
                    s_axis[j] = '0;
            end
            if (outn == stall_at && stall_left > 0) m_tready = 1'b0;
            else m_tready = ($urandom_range(99) < rprob);
            #1;
            chk("errors", errors, exp_err);
            if (busy && owner_q.size() > 0) chk("grant", grant, owner_q[0]);
            if (outn == stall_at && stall_left > 0) begin
                chk("stall_hold", {m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tvalid},
                    {exp_q[0].data, exp_q[0].keep, exp_q[0].last, 1'b1});
                chk("stall_tready", s_tready, 4'd0);
                stall_left--;
            end
            if (m_axis.tvalid && m_tready) begin
                if (exp_q.size() > 0) begin
                    hb = exp_q.pop_front();
                    chk("out_beat", {m_axis.tdata, m_axis.tkeep, m_axis.tlast}, hb);
                end
                if (outn == 0 && first_exp >= 0) chk("first_latency", cyc, first_exp);
                if (outn > 0 && gap_exp > 0) chk("packet_gap", cyc - last_out, gap_exp);
                last_out = cyc;
                outn++;
            end
            for (int j = 0; j < N; j++) begin
                if (s_axis[j].tvalid && s_tready[j]) begin
                    hb = src_q[j].pop_front();
                    if (owner_q.size() > 0) chk("accept_owner", j, owner_q[0]);
                    bcnt[j]++;
                    if (hb.last) begin
                        if (hb.keep == 16'h0000) exp_err.underflow = 1'b1;
                        bcnt[j] = 0;
                        mid[j]  = 1'b0;
                        if (owner_q.size() > 0) owner_q.delete(0);
                    end else begin
                        if (hb.keep != 16'hFFFF) exp_err.logic_error = 1'b1;
                        if (bcnt[j] >= MAXB) exp_err.overflow = 1'b1;
                        mid[j] = 1'b1;
                    end
                end
            end
            cyc++;
        end
        if (exp_q.size() > 0) chk("run_timeout", exp_q.size(), 0);
        @(negedge clk);
        clear_inputs();
        m_tready = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got;
        tv[0]  = '{4'b0101, 2'd0};  tv[1]  = '{4'b0101, 2'd2};
        tv[2]  = '{4'b0101, 2'd0};  tv[3]  = '{4'b1000, 2'd3};
        tv[4]  = '{4'b1110, 2'd1};  tv[5]  = '{4'b0011, 2'd0};
        tv[6]  = '{4'b1111, 2'd1};  tv[7]  = '{4'b1111, 2'd2};
        tv[8]  = '{4'b0100, 2'd2};  tv[9]  = '{4'b1000, 2'd3};
        tv[10] = '{4'b0010, 2'd1};  tv[11] = '{4'b0001, 2'd0};
        clear_inputs();

        do_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            for (int j = 0; j < N; j++) begin
                if (tv[i].mask[j]) drive_beat(j, mk_beat(j, 1'b1, 16'hFFFF), 1'b1);
                else s_axis[j] = '0;
            end
            got = 1'b0;
            for (int w = 0; w < 4 && !got; w++) begin
                @(posedge clk);
                #1;
                got = busy;
            end
            if (!got) begin
                chk("vec_busy", got, 1'b1);
            end else begin
                chk("vec_grant", grant, tv[i].exp_grant);
                @(posedge clk);
                #1;
                chk("vec_data", {m_axis.tvalid, m_axis.tdata[31:24]}, {1'b1, 8'(tv[i].exp_grant)});
            end
            @(negedge clk);
            clear_inputs();
        end

        do_reset();
        add_pkt(0, 3, 16'hFFFF);
        add_pkt(2, 3, 16'hFFFF);
        run(100, 100, -1, 2, 0, 200);

        for (int r = 0; r < 3; r++)
            for (int k = 0; k < N; k++) add_pkt(k, 1, 16'hFFFF);
        run(100, 100, -1, -1, 2, 200);

        add_pkt(1, 4, 16'hFFFF);
        run(100, 100, 2, -1, 0, 200);

        add_pkt(3, 6, 16'h000F);
        run(100, 100, -1, -1, 0, 200);
        chk("overflow_set", errors, 3'b100);
        clear_err();

        src_q[2].push_back(mk_beat(2, 1'b0, 16'h00FF));
        src_q[2].push_back(mk_beat(2, 1'b1, 16'h0000));
        run(100, 100, -1, -1, 0, 200);
        chk("keep_errors", errors, 3'b011);
        add_pkt(1, 2, 16'hFFFF);
        run(100, 100, -1, -1, 0, 200);
        chk("keep_sticky", errors, 3'b011);

        @(negedge clk);
        drive_beat(0, mk_beat(0, 1'b1, 16'h0000), 1'b1);
        @(negedge clk);
        err_clr = 1'b1;
        #1;
        chk("clr_tready", s_tready, 4'b0001);
        @(negedge clk);
        err_clr = 1'b0;
        clear_inputs();
        #1;
        chk("clr_priority", errors, 3'b010);
        model_ptr = 1;
        exp_err   = '{overflow: 1'b0, underflow: 1'b1, logic_error: 1'b0};
        clear_err();

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < N; k++) begin
                int npk;
                npk = $urandom_range(1, 4);
                for (int pk = 0; pk < npk; pk++) begin
                    int len;
                    len = $urandom_range(1, 5);
                    for (int b = 0; b < len; b++) begin
                        if (b == len - 1)
                            src_q[k].push_back(mk_beat(k, 1'b1, ($urandom_range(7) == 0) ?
                                16'h0000 : 16'($urandom_range(1, 65535))));
                        else
                            src_q[k].push_back(mk_beat(k, 1'b0, ($urandom_range(9) == 0) ?
                                16'h00FF : 16'hFFFF));
                    end
                end
            end
            run(70, 60, -1, -1, 0, 4000);
        end

        do_reset();
        @(negedge clk);
        drive_beat(1, mk_beat(1, 1'b0, 16'hFFFF), 1'b1);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("pre_rst_valid", m_axis.tvalid, 1'b1);
        chk("pre_rst_grant", grant, 2'd1);
        arst_n = 1'b0;
        #1;
        chk("mid_rst_m_axis", m_axis, 530'd0);
        chk("mid_rst_tready", s_tready, 4'd0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_grant", grant, 2'd0);
        chk("mid_rst_errors", errors, 3'd0);
        drive_beat(1, mk_beat(1, 1'b1, 16'hFFFF), 1'b1);
        drive_beat(3, mk_beat(3, 1'b1, 16'hFFFF), 1'b1);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_busy", busy, 1'b1);
        chk("rel_grant_1", grant, 2'd1);
        chk("rel_no_flush", m_axis.tvalid, 1'b0);
        @(negedge clk);
        arst_n = 1'b0;
        s_axis[1] = '0;
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_grant_3", grant, 2'd3);
        @(negedge clk);
        clear_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis512_rr_arb.md
AXIS512_RR_ARB -- requirements
Module: axis512_rr_arb

Interface
REQ-001 Parameter NUM_IN, default 4, number of input streams (legal 2..8).
REQ-002 Parameter MAX_PKT_BEATS, default 256, beat limit for the packet-length check (legal 2..65535).
REQ-003 clk  input  1  single clock, all logic rising-edge.
REQ-004 arst_n  input  1  reset: one clock; reset is asynchronous and active-low.
REQ-005 s_axis_i  input  NUM_IN x axis512_t  input streams (tdata 512, tkeep 16 at 32-bit granularity, tlast, tvalid).
REQ-006 s_tready_o  output  NUM_IN  per-input ready.
REQ-007 m_axis_o  output  axis512_t  merged output stream.
REQ-008 m_tready_i  input  1  downstream ready.
REQ-009 grant_o  output  clog2(NUM_IN)  index of the input currently granted.
REQ-010 busy_o  output  1  high while a packet is granted (state PASS).
REQ-011 err_clr_i  input  1  synchronous clear of errors_o.
REQ-012 errors_o  output  fifo_errors_t  sticky error flags.

Function
REQ-013 Arbitration SHALL be packet-granular round-robin: once granted, an input keeps the grant until its tlast beat is accepted.
REQ-014 FSM states SHALL be IDLE and PASS.
REQ-015 In IDLE, if any s_axis_i[k].tvalid is high, grant SHALL go to the first valid index at or after ptr (wrapping modulo NUM_IN); grant_o SHALL register it, and the FSM SHALL enter PASS on the next edge.
REQ-016 In IDLE with no valid input, the FSM SHALL stay in IDLE and ptr SHALL be unchanged.
REQ-017 s_tready_o[k] SHALL be high only when state is PASS, k equals grant_o, and the output register is empty or m_tready_i is high; all other bits SHALL be 0.
REQ-018 An accepted beat (tvalid and tready) SHALL be loaded into a single output register; m_axis_o SHALL present it the next cycle, unmodified.
REQ-019 The output register SHALL hold its contents while m_axis_o.tvalid is high and m_tready_i is low.
REQ-020 Latency SHALL be: first beat of a packet 2 cycles from tvalid seen in IDLE to m_axis_o.tvalid; subsequent beats 1 cycle; full throughput inside a packet; exactly one input-side bubble cycle between packets.
REQ-021 When the tlast beat is accepted, the FSM SHALL return to IDLE and ptr SHALL become (grant_o+1) mod NUM_IN.
REQ-022 A 16-bit beat counter SHALL count accepted beats of the current packet, starting from 1 on the first beat and clearing when tlast is accepted.
REQ-023 When the counter reaches MAX_PKT_BEATS on a beat with tlast=0, errors_o.overflow SHALL be set and forwarding SHALL continue; the counter SHALL saturate and SHALL not wrap.
REQ-024 errors_o.underflow SHALL be set when an accepted tlast beat has tkeep equal to 0.
REQ-025 errors_o.logic_error SHALL be set when an accepted non-last beat has tkeep not all ones.
REQ-026 err_clr_i SHALL clear all error flags; a new error detected in the same cycle as err_clr_i SHALL take priority and set its flag.
REQ-027 A tvalid deassertion on the granted input mid-packet SHALL only stall forwarding; the grant SHALL be held.

Reset
REQ-028 Reset SHALL force state IDLE, ptr 0, grant_o 0, busy_o 0, the beat counter 0, m_axis_o all zero (tvalid 0), s_tready_o 0, and errors_o 0.
REQ-029 Reset asserted mid-packet SHALL discard the partial packet with no flush, and on release arbitration SHALL restart from ptr 0.

Structure
REQ-030 The arbiter state enum (IDLE, PASS) and the constant AXIS512_KEEP_ALL (16'hFFFF) SHALL be added to the shared bitables package next to axis512_t and fifo_errors_t.
REQ-031 The output register with its hold logic SHALL be a sub-module named axis512_reg_slice; the arbiter, counter and error logic SHALL stay in axis512_rr_arb.

Verification
REQ-032 Inputs 0 and 2 each present a 3-beat packet in the same cycle after reset, m_tready_i=1 -> input 0's packet is output first, then input 2's, with grant_o 0 then 2 and first m_axis_o beat 2 cycles after tvalid.
REQ-033 All 4 inputs continuously present 1-beat packets -> output order 0,1,2,3,0,1,... with one bubble between packets.
REQ-034 m_tready_i held low 5 cycles mid-packet -> m_axis_o stable for those 5 cycles; no beat lost or duplicated; s_tready_o of the granted input low for those 5 cycles.
REQ-035 MAX_PKT_BEATS=4 and a 6-beat packet -> overflow set on the 4th beat; all 6 beats forwarded; err_clr_i pulse -> errors_o returns to 0.
REQ-036 Non-last beat with tkeep=16'h00FF, then a last beat with tkeep=0 -> logic_error and underflow both set, both sticky.
REQ-037 arst_n pulsed low during beat 2 of a packet from input 1 -> all outputs zero immediately; after release, input 3 valid wins before input 1 only if input 1 is not valid.
